// File: rtl/mac_switch_pkg.sv
// rtl/mac_switch_pkg.sv - shared constants and types for the MAC lookup arbiter
package mac_switch_pkg;

  localparam int MAC_W  = 48;
  localparam int PORT_W = 3;

  localparam logic [PORT_W-1:0] PORT_FLOOD   = 3'b100;
  localparam logic [PORT_W-1:0] PORT_INVALID = 3'b110;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

  // Index of the port after idx, wrapping at n; works for non-power-of-two n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first requester at or after the pointer
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] cand;
  logic             found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      // ptr_i < N and k < N, so a single conditional subtract wraps correctly
      cand = {1'b0, ptr_i} + SUM_W'(k);
      if (cand >= SUM_W'(N)) begin
        cand = cand - SUM_W'(N);
      end
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found                     = 1'b1;
        idx_o                     = cand[IDX_W-1:0];
        grant_o[cand[IDX_W-1:0]] = 1'b1;
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/mac_lookup_arbiter.sv
// rtl/mac_lookup_arbiter.sv - shares one mac_learning engine between ingress ports
// Round-robin grant, engine handshake, and a watchdog that turns a missing done into a flood.
module mac_lookup_arbiter
  import mac_switch_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0]       req_valid,
  input  logic [NUM_PORTS*MAC_W-1:0] req_src_mac,
  input  logic [NUM_PORTS*MAC_W-1:0] req_dst_mac,
  output logic [NUM_PORTS-1:0]       req_ready,
  output logic [NUM_PORTS-1:0]       rsp_valid,
  output logic [PORT_W-1:0]          rsp_dst_port,
  output logic                       rsp_timeout,
  output logic [CNT_W-1:0]           timeout_count,
  output logic                       ml_en,
  output logic [MAC_W-1:0]           ml_src_mac,
  output logic [MAC_W-1:0]           ml_dst_mac,
  output logic [PORT_W-1:0]          ml_src_port,
  input  logic                       ml_busy,
  input  logic                       ml_done,
  input  logic [PORT_W-1:0]          ml_dst_port
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t            state_q;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      winner_q;
  logic [NUM_PORTS-1:0]  grant_q;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [CNT_W-1:0]      timeout_count_q, timeout_count_d;
  logic [NUM_PORTS-1:0]  req_ready_q, rsp_valid_q;
  logic [PORT_W-1:0]     rsp_dst_port_q;
  logic                  rsp_timeout_q;
  logic                  ml_en_q;
  logic [MAC_W-1:0]      ml_src_mac_q, ml_dst_mac_q;
  logic [PORT_W-1:0]     ml_src_port_q;

  logic [NUM_PORTS-1:0]  pick_grant;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic                  timeout_hit;

  rr_arbiter #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign ptr_d           = IDX_W'(rr_next(int'(winner_q), NUM_PORTS));
  assign timer_d         = timer_q + 1'b1;
  assign timeout_hit     = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
  assign timeout_count_d = (&timeout_count_q) ? timeout_count_q : timeout_count_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ARB_IDLE;
      ptr_q           <= '0;
      winner_q        <= '0;
      grant_q         <= '0;
      timer_q         <= '0;
      timeout_count_q <= '0;
      req_ready_q     <= '0;
      rsp_valid_q     <= '0;
      rsp_dst_port_q  <= PORT_INVALID;
      rsp_timeout_q   <= 1'b0;
      ml_en_q         <= 1'b0;
      ml_src_mac_q    <= '0;
      ml_dst_mac_q    <= '0;
      ml_src_port_q   <= '0;
    end else begin
      // Strobes default low so each is a single-cycle pulse
      ml_en_q     <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        ARB_IDLE: begin
          if (!ml_busy && pick_any) begin
            ml_src_mac_q  <= req_src_mac[pick_idx*MAC_W +: MAC_W];
            ml_dst_mac_q  <= req_dst_mac[pick_idx*MAC_W +: MAC_W];
            ml_src_port_q <= PORT_W'(pick_idx);
            winner_q      <= pick_idx;
            grant_q       <= pick_grant;
            ml_en_q       <= 1'b1;
            req_ready_q   <= pick_grant;
            state_q       <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          timer_q <= '0;
          ptr_q   <= ptr_d;
          state_q <= ARB_WAIT;
        end
        ARB_WAIT: begin
          timer_q <= timer_d;
          if (ml_done) begin
            rsp_dst_port_q <= ml_dst_port;
            rsp_timeout_q  <= 1'b0;
            rsp_valid_q    <= grant_q;
            state_q        <= ARB_RESP;
          end else if (timeout_hit) begin
            rsp_dst_port_q  <= PORT_FLOOD;
            rsp_timeout_q   <= 1'b1;
            timeout_count_q <= timeout_count_d;
            rsp_valid_q     <= grant_q;
            state_q         <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          state_q <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_dst_port  = rsp_dst_port_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign timeout_count = timeout_count_q;
  assign ml_en         = ml_en_q;
  assign ml_src_mac    = ml_src_mac_q;
  assign ml_dst_mac    = ml_dst_mac_q;
  assign ml_src_port   = ml_src_port_q;

endmodule

// File: tb/tb_mac_lookup_arbiter.sv
// tb/tb_mac_lookup_arbiter.sv - directed self-checking bench for mac_lookup_arbiter
module tb_mac_lookup_arbiter;

  localparam int NP = 4;
  localparam int TO = 64;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NP-1:0]   req_valid = '0;
  logic [NP*48-1:0] req_src_mac, req_dst_mac;
  logic [NP-1:0]   req_ready, rsp_valid;
  logic [2:0]      rsp_dst_port;
  logic            rsp_timeout;
  logic [CW-1:0]   timeout_count;
  logic            ml_en;
  logic [47:0]     ml_src_mac, ml_dst_mac;
  logic [2:0]      ml_src_port;
  logic            ml_busy = 1'b0;
  logic            ml_done = 1'b0;
  logic [2:0]      ml_dst_port = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_lookup_arbiter #(
    .NUM_PORTS      (NP),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_src_mac   (req_src_mac),
    .req_dst_mac   (req_dst_mac),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_dst_port  (rsp_dst_port),
    .rsp_timeout   (rsp_timeout),
    .timeout_count (timeout_count),
    .ml_en         (ml_en),
    .ml_src_mac    (ml_src_mac),
    .ml_dst_mac    (ml_dst_mac),
    .ml_src_port   (ml_src_port),
    .ml_busy       (ml_busy),
    .ml_done       (ml_done),
    .ml_dst_port   (ml_dst_port)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ml_en(output bit got);
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (ml_en) got = 1'b1;
    end
    if (!got) check("ml_en_seen", 64'd0, 64'd1);
  endtask

  task automatic wait_rsp(output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid != '0) seen = 1'b1;
    end
    if (!seen) check("rsp_seen", 64'd0, 64'd1);
  endtask

  // Engine model: done pulse 'delay' cycles after the ml_en negedge
  task automatic respond(input int delay, input logic [2:0] dst);
    repeat (delay) @(negedge clk);
    ml_done     = 1'b1;
    ml_dst_port = dst;
    @(negedge clk);
    ml_done = 1'b0;
  endtask

  initial begin
    bit got;
    int cyc;
    int hits;

    for (int i = 0; i < NP; i++) begin
      req_src_mac[i*48 +: 48] = 48'h0A00_0000_0010 + 48'(i);
      req_dst_mac[i*48 +: 48] = 48'h0B00_0000_0020 + 48'(i);
    end

    // Reset values
    do_reset();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_ml_en", ml_en, 0);
    check("rst_rsp_dst", rsp_dst_port, 3'b110);
    check("rst_tcount", timeout_count, 0);
    check("rst_src_port", ml_src_port, 0);
    check("rst_src_mac", ml_src_mac, 0);

    // 1: single request from port 2, done 5 cycles after ml_en
    @(negedge clk);
    req_valid = 4'b0100;
    wait_ml_en(got);
    req_valid = '0;
    check("t1_src_port", ml_src_port, 2);
    check("t1_ready", req_ready, 4'b0100);
    check("t1_src_mac", ml_src_mac, 48'h0A00_0000_0012);
    check("t1_dst_mac", ml_dst_mac, 48'h0B00_0000_0022);
    @(negedge clk);
    check("t1_en_pulse", ml_en, 0);
    check("t1_ready_pulse", req_ready, 0);
    respond(4, 3'b011);
    check("t1_rsp_valid", rsp_valid, 4'b0100);
    check("t1_rsp_dst", rsp_dst_port, 3'b011);
    check("t1_rsp_to", rsp_timeout, 0);
    check("t1_mac_hold", ml_src_mac, 48'h0A00_0000_0012);
    @(negedge clk);
    check("t1_rsp_pulse", rsp_valid, 0);

    // 2: all ports requesting, round-robin order 0,1,2,3,0
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ml_en(got);
      if (k == 4) req_valid = '0;
      check("t2_order", ml_src_port, 64'(k % 4));
      check("t2_ready", req_ready, 64'(1 << (k % 4)));
      respond(2, 3'(k));
      check("t2_rsp_valid", rsp_valid, 64'(1 << (k % 4)));
      check("t2_rsp_dst", rsp_dst_port, 64'(k));
    end

    // 4: engine busy blocks grants
    do_reset();
    ml_busy   = 1'b1;
    req_valid = 4'b0010;
    hits = 0;
    repeat (20) begin
      @(negedge clk);
      if (ml_en || req_ready != '0) hits++;
    end
    check("t4_blocked", hits, 0);
    ml_busy = 1'b0;
    @(negedge clk);
    check("t4_grant_en", ml_en, 1);
    check("t4_grant_ready", req_ready, 4'b0010);
    req_valid = '0;
    respond(1, 3'b001);
    check("t4_rsp_valid", rsp_valid, 4'b0010);

    // 3: engine never answers -> watchdog flood
    do_reset();
    req_valid = 4'b0001;
    wait_ml_en(got);
    req_valid = '0;
    wait_rsp(cyc);
    check("t3_latency", cyc, TO + 1);
    check("t3_rsp_valid", rsp_valid, 4'b0001);
    check("t3_rsp_dst", rsp_dst_port, 3'b100);
    check("t3_rsp_to", rsp_timeout, 1);
    check("t3_tcount", timeout_count, 1);

    // 6: late done after the timeout response is dropped
    repeat (2) @(negedge clk);
    ml_done     = 1'b1;
    ml_dst_port = 3'b010;
    @(negedge clk);
    ml_done = 1'b0;
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid != '0) hits++;
    end
    check("t6_no_rsp", hits, 0);
    check("t6_tcount", timeout_count, 1);

    // 5: asynchronous reset mid-WAIT, then pointer restarts at 0
    req_valid = 4'b0100;
    wait_ml_en(got);
    req_valid = '0;
    check("t5_pre_port", ml_src_port, 2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_rst_src_port", ml_src_port, 0);
    check("t5_rst_src_mac", ml_src_mac, 0);
    check("t5_rst_rsp_dst", rsp_dst_port, 3'b110);
    check("t5_rst_tcount", timeout_count, 0);
    check("t5_rst_en", ml_en, 0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b1010;
    wait_ml_en(got);
    req_valid = '0;
    check("t5_grant_port", ml_src_port, 1);
    check("t5_grant_ready", req_ready, 4'b0010);
    respond(1, 3'b000);
    check("t5_rsp_valid", rsp_valid, 4'b0010);
    check("t5_rsp_dst", rsp_dst_port, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
